// File: rtl/regbank_dump_reader_pkg.sv
// Shared debug-unit definitions for the register bank dump reader:
// FSM state encoding and word/byte geometry helpers.
package regbank_dump_reader_pkg;

  localparam int DUMP_DATA_W    = 32;
  localparam int BYTES_PER_WORD = DUMP_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // Byte counter width, never narrower than one bit.
  function automatic int byte_cnt_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/regbank_dump_reader_serializer.sv
// Holds one captured register word and presents it byte by byte on a
// valid/ready stream; the byte order is fixed by MSB_FIRST.
module word_byte_serializer
  import regbank_dump_reader_pkg::*;
#(
  parameter int DATA_W    = DUMP_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              active,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              accept,
  output logic              last_byte
);

  localparam int BPW = bytes_per_word(DATA_W);
  localparam int CW  = byte_cnt_width(BPW);

  logic [DATA_W-1:0] word_reg;
  logic [CW-1:0]     byte_cnt_reg;
  logic [CW-1:0]     byte_cnt_next;
  logic [7:0]        lanes [BPW];

  // lanes[] is ordered by transmission slot, not by bit position.
  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      localparam int LANE = (MSB_FIRST != 0) ? (BPW - 1 - gi) : gi;
      assign lanes[gi] = word_reg[LANE*8 +: 8];
    end
  endgenerate

  assign tx_valid  = active;
  assign tx_data   = active ? lanes[byte_cnt_reg] : 8'h00;
  assign accept    = active & tx_ready;
  assign last_byte = (byte_cnt_reg == CW'(BPW - 1));

  always_comb begin
    byte_cnt_next = byte_cnt_reg;
    if (load) begin
      byte_cnt_next = '0;
    end else if (accept) begin
      byte_cnt_next = last_byte ? '0 : byte_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_reg     <= '0;
      byte_cnt_reg <= '0;
    end else begin
      if (load) begin
        word_reg <= word;
      end
      byte_cnt_reg <= byte_cnt_next;
    end
  end

endmodule

// File: rtl/regbank_dump_reader.sv
// Walks the register bank through one read port and streams every word
// out as bytes to the debug UART, holding the pipeline halted meanwhile.
module regbank_dump_reader
  import regbank_dump_reader_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = DUMP_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rb_addr,
  input  logic [DATA_W-1:0] rb_data,
  output logic              halt_req,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state_reg;
  dump_state_t       state_next;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] idx_next;
  logic              byte_accept;
  logic              last_byte;

  word_byte_serializer #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (state_reg == ST_WAIT),
    .word      (rb_data),
    .active    (state_reg == ST_SEND),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .accept    (byte_accept),
    .last_byte (last_byte)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ISSUE;
          idx_next   = '0;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_SEND;
      ST_SEND: begin
        if (byte_accept && last_byte) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + ADDR_W'(1);
            state_next = ST_ISSUE;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // Abort overrides everything, including a start seen in IDLE.
    if (abort) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  assign rb_addr  = (state_reg == ST_IDLE) ? '0 : idx_reg;
  assign halt_req = (state_reg != ST_IDLE);
  assign busy     = halt_req;
  assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Bench for regbank_dump_reader: an MSB-first and an LSB-first instance
// share one bank model and are checked against a byte-stream reference.
`timescale 1ns/1ps
module tb_regbank_dump_reader;

  localparam int N = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tx_ready = 1'b1;

  logic [4:0]  rb_addr_m, rb_addr_l;
  logic [31:0] rb_data_m, rb_data_l;
  logic        halt_m, halt_l, busy_m, busy_l, done_m, done_l;
  logic        tx_valid_m, tx_valid_l;
  logic [7:0]  tx_data_m, tx_data_l;

  logic [31:0] bank [N];
  logic [7:0]  obs_m [$];
  logic [7:0]  obs_l [$];

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int stall_seen = 0;

  regbank_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32), .MSB_FIRST(1)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .rb_addr(rb_addr_m), .rb_data(rb_data_m), .halt_req(halt_m),
    .tx_data(tx_data_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready),
    .busy(busy_m), .done(done_m)
  );

  regbank_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32), .MSB_FIRST(0)) dut_lsb (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .rb_addr(rb_addr_l), .rb_data(rb_data_l), .halt_req(halt_l),
    .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready),
    .busy(busy_l), .done(done_l)
  );

  always #5 clock = ~clock;

  // Synchronous bank read port: data valid the cycle after the address.
  always @(posedge clock) begin
    rb_data_m <= bank[rb_addr_m];
    rb_data_l <= bank[rb_addr_l];
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got=%0h required=%0h", tag, got, want);
    end
  endtask

  // Byte n of the dump is byte n%4 (in send order) of register n/4.
  function automatic logic [7:0] model_byte(input int n, input bit msb);
    int          r;
    int          b;
    int          sh;
    logic [31:0] w;
    r  = n / 4;
    b  = n % 4;
    sh = msb ? 8 * (3 - b) : 8 * b;
    w  = bank[r];
    return 8'(w >> sh);
  endfunction

  // Record every handshake; the byte is accepted on the following rising edge.
  always @(negedge clock) begin
    if (tx_valid_m && tx_ready) obs_m.push_back(tx_data_m);
    if (tx_valid_l && tx_ready) obs_l.push_back(tx_data_l);
    if (done_m) done_cnt = done_cnt + 1;
    if (ready_mode == 2 && obs_m.size() == 20 && tx_valid_m && !tx_ready) begin
      stall_seen = stall_seen + 1;
      check("stall_data", {24'h0, tx_data_m}, 32'hDE);
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        2:       tx_ready = !(obs_m.size() == 20 && stall_seen < 10);
        default: tx_ready = 1'b1;
      endcase
    end
  end

  task automatic start_dump();
    obs_m.delete();
    obs_l.delete();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int done_at, output int halt_drop);
    seen = 1'b0;
    done_at = 0;
    halt_drop = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done_m) begin
        seen = 1'b1;
        done_at = cyc - start_cyc + 1;
        break;
      end
      if (!halt_m) halt_drop++;
    end
  endtask

  task automatic compare_stream(input string tag, input int nbytes);
    check({tag, "_nbytes_msb"}, obs_m.size(), nbytes);
    check({tag, "_nbytes_lsb"}, obs_l.size(), nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (i < obs_m.size()) check($sformatf("%s_msb_byte%0d", tag, i), {24'h0, obs_m[i]}, {24'h0, model_byte(i, 1'b1)});
      if (i < obs_l.size()) check($sformatf("%s_lsb_byte%0d", tag, i), {24'h0, obs_l[i]}, {24'h0, model_byte(i, 1'b0)});
    end
  endtask

  task automatic full_dump(input int mode, input string tag, input bit repulse);
    bit seen;
    int done_at;
    int halt_drop;
    int d0;
    ready_mode = mode;
    stall_seen = 0;
    d0 = done_cnt;
    start_dump();
    if (repulse) begin
      repeat (2) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (46) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
    end
    wait_done(seen, done_at, halt_drop);
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_halt_during"}, halt_drop, 0);
    check({tag, "_halt_at_done"}, 32'(halt_m), 1);
    if (mode == 0) check({tag, "_done_cycle"}, done_at, 193);
    @(negedge clock);
    check({tag, "_busy_after"}, 32'(busy_m), 0);
    check({tag, "_halt_after"}, 32'(halt_m), 0);
    repeat (2) @(negedge clock);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    compare_stream(tag, 4 * N);
    $display("dump %s: mode=%0d bytes=%0d done_cycle=%0d", tag, mode, obs_m.size(), done_at);
  endtask

  initial begin
    int k;
    int d0;
    bit hit;

    // Reset state, sampled before the first clock edge.
    #2;
    check("rst_busy", 32'(busy_m), 0);
    check("rst_tx_valid", 32'(tx_valid_m), 0);
    check("rst_tx_data", {24'h0, tx_data_m}, 0);
    check("rst_done", 32'(done_m), 0);
    check("rst_rb_addr", {27'h0, rb_addr_m}, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // 1: pattern bank, ready stuck high, exact timing.
    for (int n = 0; n < N; n++) bank[n] = 32'h0100_0000 * n + n;
    full_dump(0, "pattern", 1'b0);
    if (obs_m.size() >= 8) begin
      for (int i = 0; i < 4; i++) check($sformatf("pattern_first%0d", i), {24'h0, obs_m[i]}, 0);
      check("pattern_b4", {24'h0, obs_m[4]}, 32'h01);
      check("pattern_b5", {24'h0, obs_m[5]}, 32'h00);
      check("pattern_b6", {24'h0, obs_m[6]}, 32'h00);
      check("pattern_b7", {24'h0, obs_m[7]}, 32'h01);
    end

    // 2 and 3: stall at byte 20 on DEADBEEF; LSB-first order of reg 1.
    for (int n = 0; n < N; n++) bank[n] = $urandom;
    bank[1] = 32'h1122_3344;
    bank[5] = 32'hDEAD_BEEF;
    full_dump(2, "stall", 1'b0);
    check("stall_cycles", stall_seen, 10);
    if (obs_l.size() >= 8) begin
      check("lsb_b4", {24'h0, obs_l[4]}, 32'h44);
      check("lsb_b5", {24'h0, obs_l[5]}, 32'h33);
      check("lsb_b6", {24'h0, obs_l[6]}, 32'h22);
      check("lsb_b7", {24'h0, obs_l[7]}, 32'h11);
    end

    // 4: start re-pulsed mid-dump, random backpressure.
    for (int n = 0; n < N; n++) bank[n] = $urandom;
    full_dump(1, "repulse", 1'b1);

    // start and abort together in IDLE: abort wins.
    @(posedge clock);
    #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clock);
    #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clock);
    check("start_abort_idle", 32'(busy_m), 0);

    // 5: abort while byte 37 (register 9) is on the stream.
    ready_mode = 0;
    d0 = done_cnt;
    start_dump();
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      #1;
      if (obs_m.size() >= 37) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reach37", 32'(hit), 1);
    @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    check("abort_tx_valid", 32'(tx_valid_m), 0);
    check("abort_busy", 32'(busy_m), 0);
    check("abort_busy_lsb", 32'(busy_l), 0);
    check("abort_done", 32'(done_m), 0);
    check("abort_rb_addr", {27'h0, rb_addr_m}, 0);
    repeat (3) @(negedge clock);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_done_lsb", 32'(done_l), 0);
    compare_stream("abort", 38);
    $display("dump abort: bytes=%0d", obs_m.size());
    for (int n = 0; n < N; n++) bank[n] = $urandom;
    full_dump(1, "after_abort", 1'b0);

    // 6: asynchronous reset in the middle of a SEND cycle.
    ready_mode = 1;
    k = $urandom_range(5, 120);
    start_dump();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #1;
      if (obs_m.size() >= k && tx_valid_m) begin
        hit = 1'b1;
        break;
      end
    end
    check("reset_midsend_reached", 32'(hit), 1);
    #1 reset = 1'b1;
    #1;
    check("areset_tx_valid", 32'(tx_valid_m), 0);
    check("areset_tx_data", {24'h0, tx_data_m}, 0);
    check("areset_busy", 32'(busy_m), 0);
    check("areset_halt", 32'(halt_m), 0);
    check("areset_done", 32'(done_m), 0);
    check("areset_rb_addr", {27'h0, rb_addr_m}, 0);
    check("areset_halt_lsb", 32'(halt_l), 0);
    $display("reset at byte %0d", obs_m.size());
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int n = 0; n < N; n++) bank[n] = $urandom;
    full_dump(0, "after_reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/regbank_dump_reader.md
Name: regbank_dump_reader

Overview:
- Debug-side reader for the MIPS register bank. On a start command it walks registers 0..NUM_REGS-1 through one bank read port.
- It serialises each 32-bit word as bytes onto a valid/ready byte stream, which feeds the UART transmitter of the debug unit.
- It sits beside the pipeline. While busy it requests a pipeline halt, and the top level muxes rb_addr onto the bank's addr1.

Parameters:
- NUM_REGS, 32, number of registers dumped (index 0..NUM_REGS-1).
- ADDR_W, 5, register address width.
- DATA_W, 32, register width; must be a multiple of 8.
- MSB_FIRST, 1, 1: most-significant byte sent first; 0: least-significant first.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next edge.
- rb_addr  out  ADDR_W  register index presented to bank read port.
- rb_data  in  DATA_W  bank read data; valid the cycle after rb_addr is presented.
- halt_req  out  1  high while not IDLE; top level freezes pipeline and holds bank stall low.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  byte available.
- tx_ready  in  1  transmitter accepts byte at rising edge when tx_valid and tx_ready are both high.
- busy  out  1  equals halt_req.
- done  out  1  one-cycle pulse after the last byte of the last register is accepted.

Behaviour:
- Reset (async, any time, including mid-dump) forces these values:
  - state=IDLE, idx=0, byte_cnt=0, word_q=0.
  - rb_addr=0, tx_data=0, tx_valid=0, halt_req=0, busy=0, done=0.
- States: IDLE, ISSUE, WAIT, SEND, DONE.
- IDLE:
  - start=1 -> ISSUE, idx=0.
  - start=0 -> stay in IDLE.
- ISSUE: rb_addr=idx for one cycle -> WAIT. The bank registers its read at the end of this cycle.
- WAIT: rb_data is valid. Capture into word_q at the end of the cycle, set byte_cnt=0 -> SEND.
- SEND:
  - tx_valid=1. tx_data is the byte selected by byte_cnt per MSB_FIRST (MSB_FIRST=1: byte_cnt 0 -> word_q[31:24]).
  - tx_data and tx_valid stay stable until accepted; tx_ready low stalls indefinitely.
  - On accept with byte_cnt<3: byte_cnt++.
  - On accept with byte_cnt=3 and idx<NUM_REGS-1: idx++ -> ISSUE, and tx_valid drops for the ISSUE/WAIT cycles.
  - On accept with byte_cnt=3 and idx=NUM_REGS-1: -> DONE.
- DONE: done=1 for exactly one cycle, tx_valid=0 -> IDLE.
- rb_addr holds idx in all non-IDLE states and is 0 in IDLE.
- Throughput with tx_ready stuck high:
  - 6 cycles per register (ISSUE, WAIT, 4x SEND).
  - Full dump = NUM_REGS*6 cycles + 1 DONE cycle; 193 cycles for 32 registers.
- start while not IDLE: ignored; no restart, no queueing.
- start and abort high together in IDLE: abort wins, stay in IDLE.
- abort in any non-IDLE state -> IDLE next edge, tx_valid=0, done stays low.
  - A byte accepted on the same edge as abort is counted as sent; nothing further follows.
- Register 0 is dumped like any other register; the bank value is sent unchanged, with no forced zero.
- idx is ADDR_W bits wide and never wraps; the terminal compare is against NUM_REGS-1.
- Bank writes landing during a dump are not coherent with the dump. The pipeline is halted via halt_req, so only external writes can race.

Decomposition:
- Shared debug package holds:
  - state encoding constants (IDLE=0, ISSUE=1, WAIT=2, SEND=3, DONE=4, 3 bits);
  - BYTES_PER_WORD = DATA_W/8.
- One natural sub-module: word_byte_serializer. It handles word load, byte select by byte_cnt and MSB_FIRST, and the valid/ready hold. The FSM and address counter stay in the top.

Test Plan:
1. Bank preloaded reg[n]=32'h0100_0000*n + n, tx_ready=1, start pulse:
   - 128 bytes emitted; first four are 00 00 00 00, bytes 4..7 are 01 00 00 01.
   - done pulses exactly at cycle 193 after start was sampled.
   - halt_req high throughout and low after DONE.
2. reg[5]=32'hDEADBEEF, tx_ready low for 10 cycles at byte 20:
   - tx_data=8'hDE stays stable with tx_valid=1 for all 10 cycles.
   - Sequence DE AD BE EF follows once ready.
3. MSB_FIRST=0, reg[1]=32'h11223344: bytes 4..7 are 44 33 22 11.
4. start re-pulsed at cycles 3 and 50 of a dump: ignored; exactly 128 bytes and one done pulse.
5. abort at byte 37 (reg 9):
   - next edge gives IDLE, tx_valid=0, busy=0, no done.
   - A fresh start dumps from reg 0.
6. reset asserted asynchronously mid-SEND:
   - all outputs 0 immediately, without waiting for a clock edge.
   - After deassert, start produces a full correct dump.
